// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared FSM state and command types for the I2C command sequencer
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } i2c_cmd_t;

  localparam int CMD_W = $bits(i2c_cmd_t);

endpackage

// File: rtl/i2c_cmd_fifo.sv
// rtl/i2c_cmd_fifo.sv - power-of-two command FIFO with occupancy count
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

  // Full is judged on the registered level, so a same-cycle pop never makes room.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - queues register writes and hands them one at a time to an I2C controller
// Optional transaction counter output txn_count_o when I2C_SEQ_STATS_EN is defined.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [6:0] DEV_ADDR = 7'h40
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [7:0]             cmd_reg_i,
  input  logic [7:0]             cmd_data_i,
  output logic [6:0]             ctl_address_o,
  output logic                   ctl_rw_o,
  output logic [7:0]             ctl_register_o,
  output logic [7:0]             ctl_data_o,
  output logic                   ctl_execute_o,
  input  logic                   ctl_busy_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   idle_o,
  output logic                   done_o
`ifdef I2C_SEQ_STATS_EN
  ,
  output logic [15:0]            txn_count_o
`endif
);

  seq_state_e state_q, state_d;
  i2c_cmd_t   cmd_in, fifo_head;
  i2c_cmd_t   active_q, active_d;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic       execute, done;

  assign cmd_in = i2c_cmd_t'({cmd_reg_i, cmd_data_i});

  i2c_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .wdata_i (cmd_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign cmd_ready_o = !fifo_full;

  // done is Mealy on busy falling so the IDLE pop cycle keeps execute two cycles behind it.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    fifo_pop = 1'b0;
    execute  = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          active_d = fifo_head;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        execute = 1'b1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (ctl_busy_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!ctl_busy_i) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  assign ctl_address_o  = DEV_ADDR;
  assign ctl_rw_o       = 1'b0;
  assign ctl_register_o = active_q.reg_addr;
  assign ctl_data_o     = active_q.data;
  assign ctl_execute_o  = execute;
  assign done_o         = done;
  assign idle_o         = fifo_empty && (state_q == ST_IDLE);

`ifdef I2C_SEQ_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;

  assign txn_count_d = done ? txn_count_q + 16'd1 : txn_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) txn_count_q <= '0;
    else         txn_count_q <= txn_count_d;
  end

  assign txn_count_o = txn_count_q;
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - scoreboard bench for i2c_cmd_sequencer with a busy-flag controller model
module tb_i2c_cmd_sequencer;

  localparam int         DEPTH    = 4;
  localparam logic [6:0] DEV_ADDR = 7'h40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   cmd_valid = 1'b0;
  logic [7:0]             cmd_reg = 8'h00;
  logic [7:0]             cmd_data = 8'h00;
  logic                   ctl_busy = 1'b0;
  logic                   cmd_ready;
  logic [6:0]             ctl_address;
  logic                   ctl_rw;
  logic [7:0]             ctl_register;
  logic [7:0]             ctl_data;
  logic                   ctl_execute;
  logic [$clog2(DEPTH):0] level;
  logic                   idle;
  logic                   done;
`ifdef I2C_SEQ_STATS_EN
  logic [15:0]            txn_count;
`endif

  i2c_cmd_sequencer #(
    .DEPTH    (DEPTH),
    .DEV_ADDR (DEV_ADDR)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_reg_i      (cmd_reg),
    .cmd_data_i     (cmd_data),
    .ctl_address_o  (ctl_address),
    .ctl_rw_o       (ctl_rw),
    .ctl_register_o (ctl_register),
    .ctl_data_o     (ctl_data),
    .ctl_execute_o  (ctl_execute),
    .ctl_busy_i     (ctl_busy),
    .level_o        (level),
    .idle_o         (idle),
    .done_o         (done)
`ifdef I2C_SEQ_STATS_EN
    ,
    .txn_count_o    (txn_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] sb[$];
  logic [15:0] mon_exp;
  logic [15:0] last_exec = 16'h0000;
  logic        prev_exec = 1'b0;
  int cyc = 0;
  int exec_cnt = 0;
  int done_cnt = 0;
  int done_since_rst = 0;
  int last_done_cyc = -1000;

  int busy_dly = 3;
  int busy_hold = 40;
  int dly_cnt = 0;
  int hold_cnt = 0;
  bit exec_flag = 1'b0;

  always @(posedge clk) cyc++;

  // Controller model: busy rises busy_dly cycles after an execute and stays up busy_hold cycles.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      ctl_busy = 1'b0;
      dly_cnt  = 0;
      hold_cnt = 0;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) ctl_busy = 1'b0;
    end else if (dly_cnt > 0) begin
      dly_cnt--;
      if (dly_cnt == 0) begin
        ctl_busy = 1'b1;
        hold_cnt = busy_hold;
      end
    end else if (exec_flag) begin
      dly_cnt = busy_dly;
    end
  end

  // Output monitor: pops the scoreboard on every execute pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_exec = 1'b0;
      exec_flag = 1'b0;
    end else begin
      exec_flag = ctl_execute;
      if (ctl_execute) begin
        exec_cnt++;
        vectors++;
        if (prev_exec) begin
          miscompares++;
          $display("FAIL exec_width: execute high 2+ consecutive cycles, required 1");
        end
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL exec_unexpected: got reg %h data %h, required no execute", ctl_register, ctl_data);
        end else begin
          mon_exp = sb.pop_front();
          if ({ctl_address, ctl_rw, ctl_register, ctl_data} !== {DEV_ADDR, 1'b0, mon_exp}) begin
            miscompares++;
            $display("FAIL exec_cmd: got addr %h rw %b reg %h data %h, required addr %h rw 0 reg %h data %h",
                     ctl_address, ctl_rw, ctl_register, ctl_data, DEV_ADDR, mon_exp[15:8], mon_exp[7:0]);
          end
        end
        vectors++;
        if (cyc - last_done_cyc < 2) begin
          miscompares++;
          $display("FAIL exec_spacing: execute %0d cycles after done, required >= 2", cyc - last_done_cyc);
        end
        last_exec = {ctl_register, ctl_data};
      end
      prev_exec = ctl_execute;
      if (done) begin
        done_cnt++;
        done_since_rst++;
        last_done_cyc = cyc;
        vectors++;
        if ({ctl_register, ctl_data} !== last_exec) begin
          miscompares++;
          $display("FAIL hold_stable: at done got %h, required %h", {ctl_register, ctl_data}, last_exec);
        end
      end
    end
  end

  task automatic apply_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_since_rst = 0;
    last_done_cyc = -1000;
  endtask

  task automatic push_cmd(input logic [7:0] r, input logic [7:0] d);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_reg   = r;
    cmd_data  = d;
    while (!cmd_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    vectors++;
    if (!cmd_ready) begin
      miscompares++;
      $display("FAIL push_timeout: ready %b after %0d cycles, required 1", cmd_ready, waited);
      cmd_valid = 1'b0;
      return;
    end
    sb.push_back({r, d});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(idle && !ctl_busy && hold_cnt == 0 && dly_cnt == 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (!idle) begin
      miscompares++;
      $display("FAIL idle_timeout: idle %b after %0d cycles, required 1", idle, n);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d commands never issued, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    vectors += 3;
    if (level !== 0) begin miscompares++; $display("FAIL rst_level: got %0d, required 0", level); end
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b, required 1", cmd_ready); end
    if (idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle: got %b, required 1", idle); end
    vectors += 3;
    if (ctl_execute !== 1'b0) begin miscompares++; $display("FAIL rst_exec: got %b, required 0", ctl_execute); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b, required 0", done); end
    if ({ctl_register, ctl_data} !== 16'h0000) begin
      miscompares++; $display("FAIL rst_regdata: got %h, required 0000", {ctl_register, ctl_data});
    end
    vectors += 1;
    if ({ctl_address, ctl_rw} !== {DEV_ADDR, 1'b0}) begin
      miscompares++; $display("FAIL rst_addr: got %h/%b, required %h/0", ctl_address, ctl_rw, DEV_ADDR);
    end
`ifdef I2C_SEQ_STATS_EN
    vectors += 1;
    if (txn_count !== 16'h0000) begin miscompares++; $display("FAIL rst_txn: got %h, required 0000", txn_count); end
`endif
    apply_reset();
  endtask

  task automatic test_single();
    int e0 = exec_cnt;
    int d0 = done_cnt;
    busy_dly = 3;
    busy_hold = 40;
    push_cmd(8'h06, 8'hA5);
    wait_idle(300);
    vectors += 2;
    if (exec_cnt - e0 != 1) begin miscompares++; $display("FAIL single_exec: got %0d pulses, required 1", exec_cnt - e0); end
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL single_done: got %0d pulses, required 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int e0 = exec_cnt;
    busy_dly = 3;
    busy_hold = 40;
    for (int i = 0; i < 5; i++) push_cmd(8'h10 + 8'(i), 8'hC0 + 8'(3 * i));
    vectors += 2;
    if (level !== 4) begin miscompares++; $display("FAIL b2b_level: got %0d, required 4", level); end
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready: got %b, required 0", cmd_ready); end
    cmd_valid = 1'b1;
    cmd_reg   = 8'hEE;
    cmd_data  = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    vectors++;
    if (level !== 4) begin miscompares++; $display("FAIL b2b_overfill: got level %0d, required 4", level); end
    wait_idle(1000);
    vectors++;
    if (exec_cnt - e0 != 5) begin miscompares++; $display("FAIL b2b_exec: got %0d pulses, required 5", exec_cnt - e0); end
  endtask

  task automatic test_simul_push_pop();
    int n = 0;
    busy_dly = 3;
    busy_hold = 20;
    push_cmd(8'h21, 8'h01);
    push_cmd(8'h22, 8'h02);
    push_cmd(8'h23, 8'h03);
    vectors++;
    if (level !== 2) begin miscompares++; $display("FAIL pp_pre_level: got %0d, required 2", level); end
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL pp_done_timeout: done %b, required 1", done); end
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_reg   = 8'h24;
    cmd_data  = 8'h04;
    sb.push_back(16'h2404);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    vectors++;
    if (level !== 2) begin miscompares++; $display("FAIL pp_level: got %0d, required 2", level); end
    wait_idle(500);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int e0, d0;
    busy_dly = 3;
    busy_hold = 40;
    for (int i = 0; i < 4; i++) push_cmd(8'h30 + 8'(i), 8'h5A ^ 8'(i));
    while (!ctl_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (level !== 3) begin miscompares++; $display("FAIL mid_pre_level: got %0d, required 3", level); end
    apply_reset();
    vectors += 2;
    if (level !== 0) begin miscompares++; $display("FAIL mid_level: got %0d, required 0", level); end
    if (idle !== 1'b1) begin miscompares++; $display("FAIL mid_idle: got %b, required 1", idle); end
    e0 = exec_cnt;
    d0 = done_cnt;
    repeat (100) @(posedge clk);
    #1;
    vectors += 2;
    if (exec_cnt != e0) begin miscompares++; $display("FAIL mid_exec: got %0d pulses, required 0", exec_cnt - e0); end
    if (done_cnt != d0) begin miscompares++; $display("FAIL mid_done: got %0d pulses, required 0", done_cnt - d0); end
  endtask

  task automatic test_slow_busy();
    int e0 = exec_cnt;
    int d0 = done_cnt;
    busy_dly = 10;
    busy_hold = 5;
    push_cmd(8'h7F, 8'h3C);
    wait_idle(300);
    vectors += 2;
    if (exec_cnt - e0 != 1) begin miscompares++; $display("FAIL slow_exec: got %0d pulses, required 1", exec_cnt - e0); end
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL slow_done: got %0d pulses, required 1", done_cnt - d0); end
  endtask

  task automatic test_random();
    int e0 = exec_cnt;
    for (int i = 0; i < 12; i++) begin
      busy_dly = $urandom_range(1, 4);
      busy_hold = $urandom_range(1, 6);
      push_cmd(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle(2000);
    vectors++;
    if (exec_cnt - e0 != 12) begin miscompares++; $display("FAIL rand_exec: got %0d pulses, required 12", exec_cnt - e0); end
  endtask

`ifdef I2C_SEQ_STATS_EN
  task automatic test_stats();
    vectors++;
    if (txn_count !== 16'(done_since_rst)) begin
      miscompares++;
      $display("FAIL stats_count: got %0d, required %0d", txn_count, 16'(done_since_rst));
    end
  endtask
`endif

  initial begin
    apply_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_simul_push_pop();
    test_reset_mid();
    test_slow_busy();
    test_random();
`ifdef I2C_SEQ_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h40, 7-bit target address driven on every transaction.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_valid_i  input  1  requester offers a register write.
REQ-006 SHALL have port cmd_ready_o  output  1  FIFO can accept; transfer when valid and ready are both high.
REQ-007 SHALL have port cmd_reg_i  input  8  target register.
REQ-008 SHALL have port cmd_data_i  input  8  write data.
REQ-009 SHALL have port ctl_address_o  output  7  address to controller, constant DEV_ADDR.
REQ-010 SHALL have port ctl_rw_o  output  1  constant 0 (write).
REQ-011 SHALL have port ctl_register_o  output  8  register of the active command.
REQ-012 SHALL have port ctl_data_o  output  8  data of the active command.
REQ-013 SHALL have port ctl_execute_o  output  1  one-cycle start pulse to controller.
REQ-014 SHALL have port ctl_busy_i  input  1  controller busy flag.
REQ-015 SHALL have port level_o  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port idle_o  output  1  high when FIFO is empty and FSM is in IDLE.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse per completed transaction.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: FIFO not empty -> pop head into ctl_register_o/ctl_data_o holding registers, go to ISSUE.
REQ-020 ISSUE: ctl_execute_o high for exactly this one cycle -> WAIT_BUSY.
REQ-021 WAIT_BUSY: ctl_busy_i high -> WAIT_DONE; otherwise stay, with ctl_execute_o low.
REQ-022 WAIT_DONE: ctl_busy_i low -> done_o pulse for one cycle, go to IDLE.
REQ-023 The next execute pulse SHALL occur no sooner than 2 cycles after done_o.
REQ-024 ctl_register_o/ctl_data_o SHALL stay stable from ISSUE until WAIT_DONE exits.
REQ-025 cmd_ready_o SHALL equal !full, derived from registered state only, with no combinational path from cmd_valid_i.
REQ-026 Push and pop in the same cycle SHALL both occur; level_o stays unchanged.
REQ-027 In the same cycle a pop SHALL NOT free space for a push when the FIFO is full.
REQ-028 Pointers SHALL wrap modulo DEPTH; level_o SHALL range 0..DEPTH.
REQ-029 Commands SHALL issue in strict arrival order, with no drops and no duplicates.

Reset
REQ-030 On rst_ni low: FSM IDLE, FIFO empty, level_o 0, cmd_ready_o 1, ctl_execute_o 0, done_o 0, ctl_register_o/ctl_data_o 0, idle_o 1.
REQ-031 Reset mid-transaction SHALL discard queued and active commands, with no execute or done pulse after release until a new push.

Configuration
REQ-032 With I2C_SEQ_STATS_EN defined: SHALL add output txn_count_o 16 bits, reset 0, incremented on each done_o, wrapping FFFF->0000.
REQ-033 Without I2C_SEQ_STATS_EN: the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Package i2c_seq_pkg SHALL hold the FSM state enum (2-bit) and the command struct {reg 8, data 8}.
REQ-035 The FIFO SHALL be sub-module i2c_cmd_fifo (DEPTH, 16-bit width, push/pop/full/empty/level); the FSM stays in i2c_cmd_sequencer.

Verification
REQ-036 Single push reg 8'h06, data 8'hA5 with a controller model (busy 3 cycles after execute, held 40 cycles) -> one execute pulse with reg 06/data A5/addr 40/rw 0, one done_o, idle_o returns 1.
REQ-037 Push 5 commands back-to-back with DEPTH 4 while busy is held -> cmd_ready_o low after the 4th buffered entry, no loss, execute order matches push order.
REQ-038 Simultaneous push and pop at level 2 -> level_o stays 2.
REQ-039 Assert rst_ni low during WAIT_DONE with 3 queued -> after release, level_o 0, no execute pulse for 100 cycles.
REQ-040 Controller slow to raise busy (10 cycles) -> FSM holds WAIT_BUSY, single execute pulse only.
REQ-041 I2C_SEQ_STATS_EN with 65537 transactions -> txn_count_o reads 1.
